// File: rtl/jk_counter_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jk_counter_bank_pkg
//  Description : Shared constants for the JK counter bank: mode encodings,
//                JK truth-table codes and the single-bit JK next-state helper
//                used by every JK flip-flop block.
//  Revision    : 1.0 - initial release
// ============================================================================
package jk_counter_bank_pkg;

    // Operating modes of the counter bank
    localparam logic [1:0] MODE_JK   = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // JK truth table, indexed as {J,K}
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_CLEAR  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // Next state of one JK flip-flop given its present state and inputs
    function automatic logic jk_next_bit(input logic q, input logic j, input logic k);
        logic nxt;
        case ({j, k})
            JK_HOLD:   nxt = q;
            JK_CLEAR:  nxt = 1'b0;
            JK_SET:    nxt = 1'b1;
            JK_TOGGLE: nxt = ~q;
            default:   nxt = q;
        endcase
        return nxt;
    endfunction

endpackage : jk_counter_bank_pkg
`default_nettype wire

// File: rtl/jk_counter_bank_cell.sv
`default_nettype none
// ============================================================================
//  Module      : jk_cell
//  Description : Single-bit JK flip-flop with synchronous active-high reset
//                and clock enable. Q_bar is taken from the same state bit so
//                it can never disagree with Q.
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_cell
    import jk_counter_bank_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    input  logic En,
    input  logic J,
    input  logic K,
    output logic Q,
    output logic Q_bar
);

    logic r_q;

    // State bit: reset clears, enable applies the JK truth table, else hold
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_q <= 1'b0;
        end else if (En) begin
            r_q <= jk_next_bit(r_q, J, K);
        end
    end

    assign Q     = r_q;
    assign Q_bar = ~r_q;

endmodule : jk_cell
`default_nettype wire

// File: rtl/jk_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module      : jk_counter_bank
//  Description : WIDTH-bit register built from an array of JK cells. Supports
//                direct per-bit JK control, modulo up/down counting and a
//                saturating parallel load. Counting is done by steering the
//                cells' J/K inputs with toggle masks, never by a D register.
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_counter_bank
    import jk_counter_bank_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2**WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic [1:0]       Mode,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_bar,
    output logic             Wrap,
    output logic             TC
);

    // Comparisons against MODULUS are done one bit wider so that
    // MODULUS == 2**WIDTH stays representable.
    localparam logic [WIDTH:0]   c_modulus_ext = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   c_max_ext     = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_max         = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_q_bar;
    logic [WIDTH:0]   w_q_ext;
    logic [WIDTH:0]   w_d_ext;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             r_wrap;

    assign w_q_ext = {1'b0, w_q};
    assign w_d_ext = {1'b0, D};

    // Target register value and wrap condition for the count/load modes
    always_comb begin
        w_next = w_q;
        w_wrap = 1'b0;
        case (Mode)
            MODE_UP: begin
                // Out-of-range values (reachable via JK mode) also wrap to 0
                if (w_q_ext >= c_max_ext) begin
                    w_next = '0;
                    w_wrap = 1'b1;
                end else begin
                    w_next = w_q + WIDTH'(1);
                end
            end
            MODE_DOWN: begin
                if (w_q == '0) begin
                    w_next = c_max;
                    w_wrap = 1'b1;
                end else if (w_q_ext >= c_modulus_ext) begin
                    // Out-of-range value re-enters the count range silently
                    w_next = c_max;
                end else begin
                    w_next = w_q - WIDTH'(1);
                end
            end
            MODE_LOAD: begin
                w_next = (w_d_ext >= c_modulus_ext) ? c_max : D;
            end
            default: begin
                w_next = w_q;
            end
        endcase
    end

    // Cell steering: raw J/K, set/clear for load, toggle mask for counting
    always_comb begin
        w_j = '0;
        w_k = '0;
        case (Mode)
            MODE_JK: begin
                w_j = J;
                w_k = K;
            end
            MODE_LOAD: begin
                w_j = w_next;
                w_k = ~w_next;
            end
            default: begin
                w_j = w_q ^ w_next;
                w_k = w_q ^ w_next;
            end
        endcase
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            jk_cell u_cell (
                .Clk   (Clk),
                .Reset (Reset),
                .En    (En),
                .J     (w_j[i]),
                .K     (w_k[i]),
                .Q     (w_q[i]),
                .Q_bar (w_q_bar[i])
            );
        end
    endgenerate

    // Wrap pulse: high for one cycle after an enabled edge that wrapped
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= En & w_wrap;
        end
    end

    assign Q     = w_q;
    assign Q_bar = w_q_bar;
    assign Wrap  = r_wrap;
    assign TC    = ((Mode == MODE_UP)   && (w_q == c_max)) ||
                   ((Mode == MODE_DOWN) && (w_q == '0));

endmodule : jk_counter_bank
`default_nettype wire

// File: tb/tb_jk_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jk_counter_bank
//  Description : Self-checking bench for jk_counter_bank. Two instances share
//                stimulus: one with MODULUS=10 and one with default
//                parameters (MODULUS=16). Expected states are pushed to a
//                scoreboard when each command is driven and popped after the
//                edge that applies it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_counter_bank;
    import jk_counter_bank_pkg::*;

    typedef struct {
        logic [3:0] qa;
        logic       wa;
        logic [3:0] qb;
        logic       wb;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] d;

    logic [3:0] qa, qba, qb, qbb;
    logic       wrapa, tca, wrapb, tcb;

    exp_t sb[$];
    int   mq_a;
    int   mq_b;
    int   n_cmp;
    int   n_bad;

    jk_counter_bank #(.WIDTH(4), .MODULUS(10)) u_dut_a (
        .Clk(clk), .Reset(rst), .En(en), .Mode(mode), .J(j), .K(k), .D(d),
        .Q(qa), .Q_bar(qba), .Wrap(wrapa), .TC(tca)
    );

    jk_counter_bank #(.WIDTH(4)) u_dut_b (
        .Clk(clk), .Reset(rst), .En(en), .Mode(mode), .J(j), .K(k), .D(d),
        .Q(qb), .Q_bar(qbb), .Wrap(wrapb), .TC(tcb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Reference behaviour, written from the register's functional description
    function automatic int model_next(input int q, input logic r, input logic e,
                                      input logic [1:0] m, input logic [3:0] jj,
                                      input logic [3:0] kk, input logic [3:0] dd,
                                      input int modulus, output logic w);
        logic [3:0] q4;
        int nq;
        q4 = q[3:0];
        w  = 1'b0;
        nq = q;
        if (r) begin
            nq = 0;
        end else if (e) begin
            case (m)
                MODE_JK:   nq = int'((jj & ~q4) | (~kk & q4));
                MODE_UP:   begin
                    if (q >= modulus - 1) begin nq = 0; w = 1'b1; end
                    else nq = q + 1;
                end
                MODE_DOWN: begin
                    if (q == 0) begin nq = modulus - 1; w = 1'b1; end
                    else if (q >= modulus) nq = modulus - 1;
                    else nq = q - 1;
                end
                default:   nq = (int'(dd) >= modulus) ? modulus - 1 : int'(dd);
            endcase
        end
        return nq;
    endfunction

    // Drive one command, record the expected outcome, advance past the edge
    task automatic drive_cycle(input logic r, input logic e, input logic [1:0] m,
                               input logic [3:0] jj, input logic [3:0] kk,
                               input logic [3:0] dd);
        exp_t x;
        logic w;
        rst  = r;
        en   = e;
        mode = m;
        j    = jj;
        k    = kk;
        d    = dd;
        mq_a = model_next(mq_a, r, e, m, jj, kk, dd, 10, w);
        x.qa = mq_a[3:0];
        x.wa = w;
        mq_b = model_next(mq_b, r, e, m, jj, kk, dd, 16, w);
        x.qb = mq_b[3:0];
        x.wb = w;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b1, 1'b1, MODE_UP, 4'hF, 4'h0, 4'h7);
            e = sb.pop_front();
            n_cmp++;
            if (qa !== 4'h0 || qba !== 4'hF || wrapa !== 1'b0 || qa !== e.qa) begin
                n_bad++;
                $display("FAIL reset_a: got Q=%h Q_bar=%h Wrap=%b want Q=0 Q_bar=f Wrap=0", qa, qba, wrapa);
            end
            n_cmp++;
            if (qb !== 4'h0 || qbb !== 4'hF || wrapb !== 1'b0 || qb !== e.qb) begin
                n_bad++;
                $display("FAIL reset_b: got Q=%h Q_bar=%h Wrap=%b want Q=0 Q_bar=f Wrap=0", qb, qbb, wrapb);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        exp_t e;
        logic [3:0] want_a [6] = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2};
        for (int i = 0; i < 6; i++) begin
            drive_cycle((i == 3), 1'b1, MODE_UP, 4'h0, 4'h0, 4'h0);
            e = sb.pop_front();
            n_cmp++;
            if (qa !== want_a[i] || qa !== e.qa || wrapa !== e.wa || qba !== ~e.qa) begin
                n_bad++;
                $display("FAIL reset_mid_a[%0d]: got Q=%h Q_bar=%h Wrap=%b want Q=%h Wrap=%b", i, qa, qba, wrapa, want_a[i], e.wa);
            end
            n_cmp++;
            if (qb !== e.qb || wrapb !== e.wb) begin
                n_bad++;
                $display("FAIL reset_mid_b[%0d]: got Q=%h Wrap=%b want Q=%h Wrap=%b", i, qb, wrapb, e.qb, e.wb);
            end
        end
    endtask

    task automatic test_up_wrap();
        exp_t e;
        logic [3:0] want [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                  4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
        drive_cycle(1'b1, 1'b0, MODE_JK, 4'h0, 4'h0, 4'h0);
        e = sb.pop_front();
        for (int i = 0; i < 12; i++) begin
            mode = MODE_UP;
            #1;
            n_cmp++;
            if (tca !== (qa == 4'd9)) begin
                n_bad++;
                $display("FAIL up_tc[%0d]: got TC=%b with Q=%h want TC=%b", i, tca, qa, (qa == 4'd9));
            end
            drive_cycle(1'b0, 1'b1, MODE_UP, 4'h0, 4'h0, 4'h0);
            e = sb.pop_front();
            n_cmp++;
            if (qa !== want[i] || wrapa !== (i == 9) || qa !== e.qa || qba !== ~want[i]) begin
                n_bad++;
                $display("FAIL up_wrap_a[%0d]: got Q=%h Q_bar=%h Wrap=%b want Q=%h Wrap=%b", i, qa, qba, wrapa, want[i], (i == 9));
            end
            n_cmp++;
            if (qb !== e.qb || wrapb !== e.wb) begin
                n_bad++;
                $display("FAIL up_wrap_b[%0d]: got Q=%h Wrap=%b want Q=%h Wrap=%b", i, qb, wrapb, e.qb, e.wb);
            end
        end
    endtask

    task automatic test_down_wrap();
        exp_t e;
        drive_cycle(1'b1, 1'b0, MODE_JK, 4'h0, 4'h0, 4'h0);
        e = sb.pop_front();
        mode = MODE_DOWN;
        #1;
        n_cmp++;
        if (tca !== 1'b1 || tcb !== 1'b1) begin
            n_bad++;
            $display("FAIL down_tc: got TC_a=%b TC_b=%b at Q=0 want 1 1", tca, tcb);
        end
        drive_cycle(1'b0, 1'b1, MODE_DOWN, 4'h0, 4'h0, 4'h0);
        e = sb.pop_front();
        n_cmp++;
        if (qa !== 4'd9 || wrapa !== 1'b1 || qb !== 4'd15 || wrapb !== 1'b1 || qa !== e.qa) begin
            n_bad++;
            $display("FAIL down_wrap: got Q_a=%h Wrap_a=%b Q_b=%h Wrap_b=%b want 9 1 f 1", qa, wrapa, qb, wrapb);
        end
        // Force 4'hC by setting the top two bits and clearing the bottom two
        drive_cycle(1'b0, 1'b1, MODE_JK, 4'hC, 4'h3, 4'h0);
        e = sb.pop_front();
        n_cmp++;
        if (qa !== 4'hC || wrapa !== 1'b0 || qb !== e.qb) begin
            n_bad++;
            $display("FAIL jk_force_c: got Q_a=%h Wrap_a=%b Q_b=%h want c 0 %h", qa, wrapa, qb, e.qb);
        end
        drive_cycle(1'b0, 1'b1, MODE_DOWN, 4'h0, 4'h0, 4'h0);
        e = sb.pop_front();
        n_cmp++;
        if (qa !== 4'd9 || wrapa !== 1'b0 || qb !== 4'hB || wrapb !== 1'b0) begin
            n_bad++;
            $display("FAIL down_out_of_range: got Q_a=%h Wrap_a=%b Q_b=%h Wrap_b=%b want 9 0 b 0", qa, wrapa, qb, wrapb);
        end
    endtask

    task automatic test_jk();
        exp_t e;
        drive_cycle(1'b0, 1'b1, MODE_LOAD, 4'h0, 4'h0, 4'b0101);
        e = sb.pop_front();
        n_cmp++;
        if (qa !== 4'b0101 || qb !== 4'b0101) begin
            n_bad++;
            $display("FAIL jk_preload: got Q_a=%b Q_b=%b want 0101 0101", qa, qb);
        end
        // bit3 toggle, bit2 set, bit1 clear, bit0 hold: 0101 -> 1101
        drive_cycle(1'b0, 1'b1, MODE_JK, 4'b1100, 4'b1010, 4'h0);
        e = sb.pop_front();
        n_cmp++;
        if (qa !== 4'b1101 || qa !== e.qa || wrapa !== 1'b0 || qba !== 4'b0010) begin
            n_bad++;
            $display("FAIL jk_mixed: got Q=%b Q_bar=%b Wrap=%b want Q=1101 Q_bar=0010 Wrap=0", qa, qba, wrapa);
        end
        drive_cycle(1'b0, 1'b1, MODE_JK, 4'hF, 4'hF, 4'h0);
        e = sb.pop_front();
        n_cmp++;
        if (qa !== 4'b0010 || qb !== 4'b0010 || wrapa !== 1'b0) begin
            n_bad++;
            $display("FAIL jk_toggle: got Q_a=%b Q_b=%b Wrap=%b want 0010 0010 0", qa, qb, wrapa);
        end
    endtask

    task automatic test_load();
        exp_t e;
        drive_cycle(1'b0, 1'b1, MODE_LOAD, 4'h0, 4'h0, 4'd7);
        e = sb.pop_front();
        n_cmp++;
        if (qa !== 4'd7 || qb !== 4'd7 || wrapa !== 1'b0) begin
            n_bad++;
            $display("FAIL load_7: got Q_a=%h Q_b=%h Wrap=%b want 7 7 0", qa, qb, wrapa);
        end
        drive_cycle(1'b0, 1'b1, MODE_LOAD, 4'h0, 4'h0, 4'd13);
        e = sb.pop_front();
        n_cmp++;
        if (qa !== 4'd9 || qb !== 4'd13 || qa !== e.qa) begin
            n_bad++;
            $display("FAIL load_sat: got Q_a=%h Q_b=%h want 9 d", qa, qb);
        end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b0, MODE_UP, 4'h0, 4'h0, 4'h0);
            e = sb.pop_front();
            n_cmp++;
            if (qa !== 4'd9 || wrapa !== 1'b0 || qb !== 4'd13 || wrapb !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_en0[%0d]: got Q_a=%h Wrap_a=%b Q_b=%h Wrap_b=%b want 9 0 d 0", i, qa, wrapa, qb, wrapb);
            end
            n_cmp++;
            if (tca !== 1'b1 || tcb !== 1'b0) begin
                n_bad++;
                $display("FAIL tc_en0[%0d]: got TC_a=%b TC_b=%b want 1 0", i, tca, tcb);
            end
        end
    endtask

    task automatic test_default_params();
        exp_t e;
        int wraps;
        drive_cycle(1'b1, 1'b0, MODE_JK, 4'h0, 4'h0, 4'h0);
        e = sb.pop_front();
        wraps = 0;
        for (int i = 0; i < 16; i++) begin
            drive_cycle(1'b0, 1'b1, MODE_UP, 4'h0, 4'h0, 4'h0);
            e = sb.pop_front();
            if (wrapb === 1'b1) wraps++;
            n_cmp++;
            if (qb !== e.qb || wrapb !== e.wb || qbb !== ~e.qb) begin
                n_bad++;
                $display("FAIL default_up[%0d]: got Q=%h Q_bar=%h Wrap=%b want Q=%h Wrap=%b", i, qb, qbb, wrapb, e.qb, e.wb);
            end
        end
        n_cmp++;
        if (qb !== 4'h0 || wraps != 1) begin
            n_bad++;
            $display("FAIL default_cycle: got Q=%h wraps=%0d want Q=0 wraps=1", qb, wraps);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 40; i++) begin
            drive_cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                        2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 4'($urandom));
            e = sb.pop_front();
            n_cmp++;
            if (qa !== e.qa || wrapa !== e.wa || qba !== ~e.qa) begin
                n_bad++;
                $display("FAIL b2b_a[%0d]: got Q=%h Q_bar=%h Wrap=%b want Q=%h Wrap=%b", i, qa, qba, wrapa, e.qa, e.wa);
            end
            n_cmp++;
            if (qb !== e.qb || wrapb !== e.wb || qbb !== ~e.qb) begin
                n_bad++;
                $display("FAIL b2b_b[%0d]: got Q=%h Q_bar=%h Wrap=%b want Q=%h Wrap=%b", i, qb, qbb, wrapb, e.qb, e.wb);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        mq_a  = 0;
        mq_b  = 0;
        rst   = 1'b1;
        en    = 1'b0;
        mode  = MODE_JK;
        j     = '0;
        k     = '0;
        d     = '0;
        test_reset();
        test_reset_mid_count();
        test_up_wrap();
        test_down_wrap();
        test_jk();
        test_load();
        test_default_params();
        test_back_to_back();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_jk_counter_bank
`default_nettype wire
